// File: rtl/count_bcd_display_if.sv
// Bundle of the count value strobe, conversion status, BCD result and display pins.
// The counter side is the master; count_bcd_display is the slave.
interface count_bcd_display_if;
  logic [7:0] value;
  logic       value_valid;
  logic       freeze;
  logic       busy;
  logic       done;
  logic [3:0] bcd_hun;
  logic [3:0] bcd_ten;
  logic [3:0] bcd_one;
  logic [6:0] seg;
  logic [2:0] dig_en;

  modport master (
    output value, value_valid, freeze,
    input  busy, done, bcd_hun, bcd_ten, bcd_one, seg, dig_en
  );

  modport slave (
    input  value, value_valid, freeze,
    output busy, done, bcd_hun, bcd_ten, bcd_one, seg, dig_en
  );
endinterface

// File: rtl/count_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter (one shift per clock) feeding a
// time-multiplexed 3-digit 7-segment scanner with optional leading-zero blanking.
module count_bcd_display #(
  parameter int SCAN_DIV = 1024,
  parameter bit LZB      = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  count_bcd_display_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t      state_q;
  logic [19:0] shift_q;
  logic [2:0]  iter_q;
  logic        pend_q;
  logic [7:0]  pend_val_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  bcd_hun_q, bcd_ten_q, bcd_one_q;
  logic [3:0]  disp_hun_q, disp_ten_q, disp_one_q;
  logic [PW-1:0] presc_q;
  logic [1:0]  scan_idx_q;
  logic [6:0]  seg_q, seg_d;
  logic [2:0]  dig_en_q, dig_en_d;

  logic [19:0] adj_d;
  logic [19:0] shifted_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_q[8+4*gi +: 4];
      assign adj_d[8+4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign adj_d[7:0] = shift_q[7:0];
  assign shifted_d  = {adj_d[18:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      iter_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_hun_q  <= '0;
      bcd_ten_q  <= '0;
      bcd_one_q  <= '0;
      disp_hun_q <= '0;
      disp_ten_q <= '0;
      disp_one_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (done_q && !bus.freeze) begin
        disp_hun_q <= bcd_hun_q;
        disp_ten_q <= bcd_ten_q;
        disp_one_q <= bcd_one_q;
      end
      case (state_q)
        S_IDLE: begin
          // A fresh strobe takes priority over a queued value.
          if (bus.value_valid || pend_q) begin
            shift_q <= {12'b0, bus.value_valid ? bus.value : pend_val_q};
            iter_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shift_q <= shifted_d;
          iter_q  <= iter_q + 3'd1;
          if (bus.value_valid) begin
            pend_val_q <= bus.value;
            pend_q     <= 1'b1;
          end
          if (iter_q == 3'd7) begin
            bcd_hun_q <= shifted_d[19:16];
            bcd_ten_q <= shifted_d[15:12];
            bcd_one_q <= shifted_d[11:8];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    logic [3:0] digit;
    logic       blank;
    digit    = disp_one_q;
    blank    = 1'b0;
    dig_en_d = 3'b001;
    case (scan_idx_q)
      2'd1: begin
        digit    = disp_ten_q;
        blank    = LZB && (disp_hun_q == 4'd0) && (disp_ten_q == 4'd0);
        dig_en_d = 3'b010;
      end
      2'd2: begin
        digit    = disp_hun_q;
        blank    = LZB && (disp_hun_q == 4'd0);
        dig_en_d = 3'b100;
      end
      default: ;
    endcase
    seg_d = blank ? 7'h00 : seg_code(digit);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      presc_q    <= '0;
      scan_idx_q <= 2'd0;
      seg_q      <= 7'h3F;
      dig_en_q   <= 3'b001;
    end else begin
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q    <= '0;
        scan_idx_q <= (scan_idx_q == 2'd2) ? 2'd0 : scan_idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_hun = bcd_hun_q;
  assign bus.bcd_ten = bcd_ten_q;
  assign bus.bcd_one = bcd_one_q;
  assign bus.seg     = seg_q;
  assign bus.dig_en  = dig_en_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display: two instances (blanking on/off) share
// stimulus; results are compared against an arithmetic model of digits and scan timing.
module tb_count_bcd_display;
  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] value;
  logic       value_valid;
  logic       freeze;

  count_bcd_display_if bus1 ();
  count_bcd_display_if bus0 ();

  assign bus1.value       = value;
  assign bus1.value_valid = value_valid;
  assign bus1.freeze      = freeze;
  assign bus0.value       = value;
  assign bus0.value_valid = value_valid;
  assign bus0.freeze      = freeze;

  count_bcd_display #(.SCAN_DIV(SCAN_DIV), .LZB(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  count_bcd_display #(.SCAN_DIV(SCAN_DIV), .LZB(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;      // clocks since the last reset edge
  int disp_v = 0; // value the display is expected to show

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always @(posedge clk) begin
    if (rst_n) k <= 0;
    else       k <= k + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd12(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int slot, input bit lzb);
    int  d;
    bit  blank;
    d     = (slot == 0) ? v % 10 : (slot == 1) ? (v / 10) % 10 : v / 100;
    blank = lzb && ((slot == 2 && v < 100) || (slot == 1 && v < 10));
    return blank ? 7'h00 : seg_tab[d];
  endfunction

  function automatic logic [2:0] exp_dig_en();
    int idx;
    idx = (k == 0) ? 0 : ((k - 1) / SCAN_DIV) % 3;
    return 3'(1 << idx);
  endfunction

  task automatic convert(input int v);
    @(negedge clk);
    value = 8'(v);
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    chk("busy_after_accept", bus1.busy, 1);
    chk("done_after_accept", bus1.done, 0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("busy_during_shift", bus1.busy, 1);
      chk("done_during_shift", bus1.done, 0);
    end
    @(negedge clk);
    chk("done_at_8", bus1.done, 1);
    chk("busy_at_8", bus1.busy, 0);
    chk("bcd_lzb1", {bus1.bcd_hun, bus1.bcd_ten, bus1.bcd_one}, bcd12(v));
    chk("bcd_lzb0", {bus0.bcd_hun, bus0.bcd_ten, bus0.bcd_one}, bcd12(v));
    $display("convert value=%0d freeze=%0b bcd=%0d/%0d/%0d", v, freeze,
             bus1.bcd_hun, bus1.bcd_ten, bus1.bcd_one);
    if (!freeze) disp_v = v;
    @(negedge clk);
    chk("done_one_cycle", bus1.done, 0);
  endtask

  task automatic check_scan();
    for (int s = 0; s < 3; s++) begin
      bit found = 1'b0;
      for (int t = 0; t < 3 * SCAN_DIV + 2 && !found; t++) begin
        @(negedge clk);
        if (bus1.dig_en == 3'(1 << s)) found = 1'b1;
      end
      chk("scan_slot_found", 32'(found), 1);
      if (found) begin
        chk("scan_dig_en", bus1.dig_en, exp_dig_en());
        chk("scan_seg_lzb1", bus1.seg, exp_seg(disp_v, s, 1'b1));
        chk("scan_seg_lzb0", bus0.seg, exp_seg(disp_v, s, 1'b0));
        $display("scan disp=%0d dig_en=%03b seg1=%02h seg0=%02h", disp_v,
                 bus1.dig_en, bus1.seg, bus0.seg);
      end
    end
  endtask

  task automatic pend_seq(input int v0, input int v1, input int v2, input bit use3);
    int          tq[$];
    logic [11:0] rq[$];
    int          last;
    last = use3 ? v2 : v1;
    for (int c = 0; c < 25; c++) begin
      if (c == 0)              begin value = 8'(v0); value_valid = 1'b1; end
      else if (c == 3)         begin value = 8'(v1); value_valid = 1'b1; end
      else if (c == 5 && use3) begin value = 8'(v2); value_valid = 1'b1; end
      else                     value_valid = 1'b0;
      @(negedge clk);
      if (bus1.done) begin
        tq.push_back(c);
        rq.push_back({bus1.bcd_hun, bus1.bcd_ten, bus1.bcd_one});
      end
    end
    value_valid = 1'b0;
    chk("pend_done_count", tq.size(), 2);
    if (tq.size() >= 2) begin
      chk("pend_first_time", tq[0], 8);
      chk("pend_first_bcd", rq[0], bcd12(v0));
      chk("pend_second_time", tq[1], 17);
      chk("pend_second_bcd", rq[1], bcd12(last));
      $display("pending seq %0d,%0d%s -> done@%0d %03h, done@%0d %03h", v0, v1,
               use3 ? ",+third" : "", tq[0], rq[0], tq[1], rq[1]);
    end
    disp_v = last;
  endtask

  initial begin
    rst_n = 1'b1;
    value = '0;
    value_valid = 1'b0;
    freeze = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus1.busy, 0);
    chk("rst_done", bus1.done, 0);
    chk("rst_bcd", {bus1.bcd_hun, bus1.bcd_ten, bus1.bcd_one}, 12'h000);
    chk("rst_dig_en", bus1.dig_en, 3'b001);
    chk("rst_seg", bus1.seg, 7'h3F);
    rst_n = 1'b0;

    // Scan rotation with no skipped or duplicated slot.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("scan_sequence", bus1.dig_en, exp_dig_en());
    end

    convert(255);
    check_scan();
    convert(7);
    check_scan();

    pend_seq(100, 42, 0, 1'b0);
    pend_seq(100, 42, 9, 1'b1);
    check_scan();

    // Reset in the middle of a conversion.
    @(negedge clk);
    value = 8'd199;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    disp_v = 0;
    chk("midrst_busy", bus1.busy, 0);
    chk("midrst_done", bus1.done, 0);
    chk("midrst_bcd", {bus1.bcd_hun, bus1.bcd_ten, bus1.bcd_one}, 12'h000);
    chk("midrst_dig_en", bus1.dig_en, 3'b001);
    chk("midrst_seg", bus1.seg, 7'h3F);
    begin
      int dones = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus1.done) dones++;
      end
      chk("midrst_no_done", dones, 0);
    end
    $display("reset during conversion of 199");

    convert(7);
    freeze = 1'b1;
    convert(58);
    check_scan();
    freeze = 1'b0;
    check_scan();
    convert(58);
    check_scan();

    for (int n = 0; n < 6; n++) begin
      convert(int'($urandom_range(0, 255)));
      check_scan();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
